// File: rtl/axis_frame_pass_sequencer_if.sv
// axis_frame_pass_sequencer_if: AXI4-Stream bundle with master/slave views
interface axis_frame_pass_sequencer_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] TDATA;
  logic              TVALID;
  logic              TREADY;
  logic              TLAST;
  logic              TUSER;
  modport master(output TDATA, TVALID, TLAST, TUSER, input TREADY);
  modport slave(input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/axis_frame_pass_sequencer.sv
// axis_frame_pass_sequencer: frames pixels into SOF/TLAST-tagged passes through one register slice
module axis_frame_pass_sequencer #(
  parameter int DATA_W        = 32,
  parameter int IMG_W         = 512,
  parameter int IMG_H         = 512,
  parameter int NUM_PASSES    = 2,
  parameter int LAST_PER_LINE = 0
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         enable,
  input  logic                         clear_err,
  axis_frame_pass_sequencer_if.slave   s_axis,
  axis_frame_pass_sequencer_if.master  m_axis,
  output logic [(NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1)-1:0] pass_idx,
  output logic                         pass_done,
  output logic                         seq_done,
  output logic                         err_early_last
);
  localparam int XW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int PW = NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t            r_state, w_next;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [PW-1:0]     r_in_pass, r_pass_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_valid, r_last, r_user, r_eof, r_eos, r_err;
  logic              w_s_ready, w_s_hs, w_m_hs, w_x_last, w_y_last, w_frame_last, w_early, w_in_pass_last;
  assign w_x_last       = r_x == XW'(IMG_W - 1);
  assign w_y_last       = r_y == YW'(IMG_H - 1);
  assign w_frame_last   = w_x_last && w_y_last;
  assign w_in_pass_last = r_in_pass == PW'(NUM_PASSES - 1);
  assign w_s_hs         = s_axis.TVALID && w_s_ready;
  assign w_m_hs         = r_valid && m_axis.TREADY;
  assign w_early        = w_s_hs && s_axis.TLAST && !w_frame_last;
  // FSM state register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next state and input ready; an early upstream TLAST aborts the pass into DRAIN
  always_comb begin
    w_next    = r_state;
    w_s_ready = 1'b0;
    case (r_state)
      IDLE:   w_next = enable ? STREAM : IDLE;
      STREAM: begin
        w_s_ready = !r_valid || m_axis.TREADY;
        w_next    = w_s_hs && (w_frame_last || s_axis.TLAST) ? DRAIN : STREAM;
      end
      DRAIN:  w_next = !r_valid || m_axis.TREADY ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // Input-side pixel, line and pass counters
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_x       <= '0;
      r_y       <= '0;
      r_in_pass <= '0;
    end else if (w_s_hs) begin
      r_x <= w_x_last || w_early ? '0 : r_x + 1'b1;
      r_y <= w_early || w_frame_last ? '0 : w_x_last ? r_y + 1'b1 : r_y;
      if (w_frame_last) r_in_pass <= w_in_pass_last ? '0 : r_in_pass + 1'b1;
    end
  end
  // Output register slice; eof/eos travel with the beat so pass bookkeeping happens on the M handshake
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_user  <= 1'b0;
      r_eof   <= 1'b0;
      r_eos   <= 1'b0;
    end else if (w_s_hs) begin
      r_valid <= 1'b1;
      r_data  <= s_axis.TDATA;
      r_user  <= r_x == '0 && r_y == '0;
      r_last  <= (w_x_last && ((LAST_PER_LINE != 0) || w_y_last)) || s_axis.TLAST;
      r_eof   <= w_frame_last;
      r_eos   <= w_frame_last && w_in_pass_last;
    end else if (m_axis.TREADY) r_valid <= 1'b0;
  end
  // Output-side pass index, advanced only by completed frames
  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_pass_idx <= '0;
    else if (w_m_hs && r_eof) r_pass_idx <= r_pass_idx == PW'(NUM_PASSES - 1) ? '0 : r_pass_idx + 1'b1;
  end
  // Sticky early-TLAST flag; a new event beats a simultaneous clear
  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_err <= 1'b0;
    else if (w_early) r_err <= 1'b1;
    else if (clear_err) r_err <= 1'b0;
  end
  assign s_axis.TREADY  = w_s_ready;
  assign m_axis.TVALID  = r_valid;
  assign m_axis.TDATA   = r_data;
  assign m_axis.TLAST   = r_last;
  assign m_axis.TUSER   = r_user;
  assign pass_idx       = r_pass_idx;
  assign pass_done      = w_m_hs && r_eof;
  assign seq_done       = w_m_hs && r_eos;
  assign err_early_last = r_err;
endmodule

// File: doc/axis_frame_pass_sequencer.md
# axis_frame_pass_sequencer

AXI4-Stream framing and pass-sequencing stage placed directly in front of the haze-removal top level. It counts pixels against a parametrised frame geometry and tags every frame with TUSER start-of-frame and a generated TLAST. It also tracks which processing pass is running: pass 0 feeds atmospheric-light estimation, and later passes feed transmission estimation and SRSC. Upstream DMA or bench sources therefore no longer need to drive TLAST correctly or honour pass boundaries by hand.

## Interface
Parameters:
- DATA_W, 32: TDATA width in bits; pixel is {8'h00, R, G, B}.
- IMG_W, 512: pixels per line; must be ≥ 2.
- IMG_H, 512: lines per frame; must be ≥ 1.
- NUM_PASSES, 2: frames per sequence; must be ≥ 1.
- LAST_PER_LINE, 0: 0 means TLAST only on the final pixel of the frame; 1 means TLAST on the final pixel of every line.

Ports:
- ACLK, in, 1: clock.
- ARESETn, in, 1: reset, synchronous, active-low; clock ACLK.
- enable, in, 1: permits a new pass to start.
- S_AXIS_TDATA, in, DATA_W: input pixel.
- S_AXIS_TVALID, in, 1: input valid.
- S_AXIS_TLAST, in, 1: optional upstream end-of-frame marker; used only for error checking.
- S_AXIS_TREADY, out, 1: input ready.
- M_AXIS_TDATA, out, DATA_W: registered pixel.
- M_AXIS_TVALID, out, 1: output valid.
- M_AXIS_TREADY, in, 1: downstream ready.
- M_AXIS_TLAST, out, 1: generated end-of-frame or end-of-line marker.
- M_AXIS_TUSER, out, 1: start of frame; high on pixel (0,0) of each pass.
- pass_idx, out, max(1,clog2(NUM_PASSES)): index of the pass currently on the output side.
- pass_done, out, 1: one-cycle pulse when the last beat of a pass handshakes on M.
- seq_done, out, 1: one-cycle pulse when the last beat of pass NUM_PASSES-1 handshakes on M.
- err_early_last, out, 1: sticky; upstream TLAST arrived before the final pixel of the frame.
- clear_err, in, 1: synchronous clear of err_early_last.

## Operation
- FSM states:
  - IDLE: S_AXIS_TREADY=0. Moves to STREAM on the first cycle enable=1.
  - STREAM: accepts beats. Moves to DRAIN when the last pixel of the frame is accepted on S.
  - DRAIN: S_AXIS_TREADY=0. Stays until the output register empties (M handshake of the last beat), then returns to IDLE.
- enable is sampled only in IDLE. Deasserting it mid-pass has no effect until the pass completes.
- Counters:
  - x counts 0..IMG_W-1 and wraps to 0.
  - On x wrap, y counts 0..IMG_H-1.
  - On y wrap at the last pixel, the input-side pass counter advances modulo NUM_PASSES.
  - Counter widths are clog2 of their range.
- Output tags are computed from the input-side counters and registered together with TDATA:
  - TUSER = (x==0 && y==0).
  - TLAST = (x==IMG_W-1) && (LAST_PER_LINE || y==IMG_H-1).
- pass_idx is output-side. It advances on the M handshake of the last beat of a frame, wrapping to 0 after NUM_PASSES-1. pass_done and seq_done pulse in that same cycle.
- Early TLAST: if S_AXIS_TLAST=1 on an accepted beat that is not the final pixel of the frame:
  - set err_early_last;
  - force M_AXIS_TLAST=1 on that beat;
  - reset x and y to 0 and go to DRAIN;
  - the pass is aborted, so pass_idx does not advance and pass_done does not pulse.
- S_AXIS_TLAST on the true final pixel, or absent there, is accepted silently.
- clear_err=1 clears err_early_last. If a clear and a new early-TLAST event occur in the same cycle, the set wins.

## Timing
- Reset values:
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TUSER=0, M_AXIS_TDATA=0.
  - S_AXIS_TREADY=0, pass_idx=0, pass_done=0, seq_done=0, err_early_last=0.
  - FSM in IDLE; x, y and the input-side pass counter all 0.
- Reset mid-frame discards the in-flight beat and restarts at pass 0.
- Datapath is a single register slice:
  - S_AXIS_TREADY = (state==STREAM) && (!M_AXIS_TVALID || M_AXIS_TREADY).
  - Latency is 1 cycle from S handshake to M_AXIS_TVALID.
  - Full throughput of 1 beat/cycle when M_AXIS_TREADY is held high.
- While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, M_AXIS_TDATA, TLAST and TUSER hold stable.
- Pass turnaround is at least 2 bubble cycles: DRAIN exit, then IDLE with enable=1.

## Test plan
Use IMG_W=4, IMG_H=2, NUM_PASSES=2, LAST_PER_LINE=0 unless stated.
- Reset: hold ARESETn=0 with S_AXIS_TVALID=1 -> all outputs 0, no S handshake.
- Two passes: enable=1, M_AXIS_TREADY=1, 16 beats with TDATA=0..15:
  - TUSER on the M beats with TDATA=0 and TDATA=8;
  - TLAST on TDATA=7 and TDATA=15;
  - pass_done pulses on the cycles of beats 7 and 15;
  - pass_idx is 0 then 1, then returns to 0;
  - seq_done pulses once, on beat 15.
- Backpressure: toggle M_AXIS_TREADY 1,0,0,1 repeatedly -> all 8 beats arrive in order, M signals stable during stalls, no S beat accepted while the output register is full and stalled.
- Line mode (LAST_PER_LINE=1): 8 beats -> M_AXIS_TLAST on beats 3 and 7 only.
- Early TLAST: S_AXIS_TLAST=1 on beat 2 ->
  - err_early_last=1 and M_AXIS_TLAST=1 on beat 2;
  - pass_idx stays 0 and pass_done does not pulse;
  - the next pass restarts at TUSER;
  - after clear_err=1 for one cycle, err_early_last=0.
- Enable gating: enable=0 -> S_AXIS_TREADY stays 0. Drop enable mid-pass -> the pass completes, and no new pass starts until enable=1.
